arb_grant_ctrl: RTL and testbench

Sequential grant controller for 4 masters sharing one downstream port (DDR/user bus). It latches requests, picks the next owner by round-robin, holds a one-hot grant for a whole burst, counts acknowledged beats, and releases the grant on completion or on a stall timeout. It also keeps the "current owner" history that sets round-robin priority for the next arbitration.

---
 rtl/arb_grant_ctrl.sv | 145 ++++++++++++++
 tb/tb_arb_grant_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_grant_ctrl.sv
// arb_grant_ctrl: round-robin burst grant controller for 4 masters sharing one port.
// Latches the winner's burst length, counts acknowledged beats, and releases the
// grant on the last beat or after a stall timeout, rotating priority in both cases.
module arb_grant_ctrl #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned TO_W   = 10,
    parameter int unsigned TO_CYC = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arb_en,
    input  logic [3:0]           req,
    input  logic [4*LEN_W-1:0]   req_len,
    input  logic                 beat_ack,
    output logic [3:0]           grant,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 last_beat,
    output logic                 done,
    output logic                 timeout
);

    localparam int unsigned NUM_M = 4;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_grant, w_grant_nxt;
    logic [1:0]         r_grant_id, w_grant_id_nxt;
    logic [1:0]         r_cur_id, w_cur_id_nxt;
    logic [LEN_W-1:0]   r_len_q, w_len_nxt;
    logic [LEN_W-1:0]   r_beat_cnt, w_beat_nxt;
    logic [TO_W-1:0]    r_to_cnt, w_to_nxt;
    logic               r_done, w_done_nxt;
    logic               r_timeout, w_timeout_nxt;

    logic [1:0]         w_pick;
    logic [1:0]         w_idx;
    logic               w_any;

    // Round-robin pick: first requester after r_cur_id, r_cur_id itself last.
    always_comb begin
        w_pick = r_cur_id;
        w_idx  = r_cur_id;
        w_any  = 1'b0;
        for (int k = NUM_M; k >= 1; k--) begin
            w_idx = r_cur_id + 2'(k);
            if (req[w_idx]) begin
                w_pick = w_idx;
                w_any  = 1'b1;
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_cur_id   <= 2'd3;
            r_len_q    <= '0;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_cur_id   <= w_cur_id_nxt;
            r_len_q    <= w_len_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_to_cnt   <= w_to_nxt;
            r_done     <= w_done_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state: arbitrate in IDLE/DONE, count beats and stall cycles in BUSY.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_cur_id_nxt   = r_cur_id;
        w_len_nxt      = r_len_q;
        w_beat_nxt     = r_beat_cnt;
        w_to_nxt       = r_to_cnt;
        w_done_nxt     = 1'b0;
        w_timeout_nxt  = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (arb_en && w_any) begin
                    w_state_nxt    = S_BUSY;
                    w_grant_nxt    = 4'b0001 << w_pick;
                    w_grant_id_nxt = w_pick;
                    w_len_nxt      = req_len[32'(w_pick) * LEN_W +: LEN_W];
                    w_beat_nxt     = '0;
                    w_to_nxt       = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end
            end
            S_BUSY: begin
                if (beat_ack) begin
                    w_to_nxt = '0;
                    if (r_beat_cnt == r_len_q) begin
                        w_state_nxt  = S_DONE;
                        w_grant_nxt  = '0;
                        w_done_nxt   = 1'b1;
                        w_cur_id_nxt = r_grant_id;
                    end else begin
                        w_beat_nxt = r_beat_cnt + LEN_W'(1);
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt   = S_DONE;
                    w_grant_nxt   = '0;
                    w_timeout_nxt = 1'b1;
                    w_cur_id_nxt  = r_grant_id;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == S_BUSY);
    assign last_beat = busy && (r_beat_cnt == r_len_q);
    assign done      = r_done;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Testbench for arb_grant_ctrl: directed scenarios plus randomized traffic,
// compared cycle by cycle against a burst-level reference model.
module tb_arb_grant_ctrl;

    localparam int unsigned LEN_W  = 8;
    localparam int unsigned TO_W   = 10;
    localparam int unsigned TO_CYC = 1000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 arb_en;
    logic [3:0]           req;
    logic [4*LEN_W-1:0]   req_len;
    logic                 beat_ack;
    logic [3:0]           grant;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 last_beat;
    logic                 done;
    logic                 timeout;

    int n_vec = 0;
    int n_err = 0;
    int n_tick = 0;

    arb_grant_ctrl #(.LEN_W(LEN_W), .TO_W(TO_W), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .req(req), .req_len(req_len),
        .beat_ack(beat_ack), .grant(grant), .grant_id(grant_id), .busy(busy),
        .last_beat(last_beat), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: owner (-1 = none), beats still owed, stall length, priority pointer.
    int m_owner, m_gid, m_left, m_stall, m_cur;
    bit m_done, m_to;

    function automatic void model_reset();
        m_owner = -1; m_gid = 0; m_left = 0; m_stall = 0; m_cur = 3;
        m_done = 0; m_to = 0;
    endfunction

    function automatic void model_edge();
        int idx;
        logic [LEN_W-1:0] l;
        m_done = 0; m_to = 0;
        if (m_owner >= 0) begin
            if (beat_ack) begin
                m_left--; m_stall = 0;
                if (m_left == 0) begin m_cur = m_owner; m_owner = -1; m_done = 1; end
            end else begin
                m_stall++;
                if (m_stall == int'(TO_CYC)) begin m_cur = m_owner; m_owner = -1; m_to = 1; end
            end
        end else if (arb_en && (req != 4'b0)) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_cur + k) % 4;
                if (req[idx] && m_owner < 0) begin
                    m_owner = idx;
                    m_gid   = idx;
                    l       = req_len[idx*LEN_W +: LEN_W];
                    m_left  = int'(l) + 1;
                    m_stall = 0;
                end
            end
        end
    endfunction

    function automatic logic [9:0] model_out();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        return {g, 2'(m_gid), 1'(m_owner >= 0), 1'(m_owner >= 0 && m_left == 1),
                1'(m_done), 1'(m_to)};
    endfunction

    wire [9:0] w_act = {grant, grant_id, busy, last_beat, done, timeout};

    // One clock: model follows the edge, outputs are then sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        n_tick++;
    endtask

    task automatic set_len(input int m, input int l);
        req_len[m*LEN_W +: LEN_W] = LEN_W'(l);
    endtask

    task automatic apply_reset();
        rst = 1'b1; arb_en = 1'b0; req = 4'b0; req_len = '0; beat_ack = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        if (w_act !== 10'b0) begin
            $display("FAIL reset_state: got %b expected %b", w_act, 10'b0); n_err++;
        end
        n_vec++;
        arb_en = 1'b1; beat_ack = 1'b1;
        tick();
        if (w_act !== model_out()) begin
            $display("FAIL reset_idle_no_req: got %b expected %b", w_act, model_out()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_single();
        logic [3:0] exp_g [1:6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        apply_reset();
        req = 4'b0001; set_len(0, 3); arb_en = 1'b1; beat_ack = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (w_act !== model_out() || grant !== exp_g[i] || last_beat !== (i == 4) ||
                done !== (i == 5)) begin
                $display("FAIL single_burst c%0d: got %b expected %b grant %b", i, w_act,
                         model_out(), exp_g[i]);
                n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_rotate();
        int dones = 0;
        logic [3:0] eg;
        apply_reset();
        req = 4'b1111; req_len = '0; arb_en = 1'b1; beat_ack = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            eg = (i % 2 == 1) ? 4'(1 << (((i - 1) / 2) % 4)) : 4'b0;
            if (done) dones++;
            if (w_act !== model_out() || grant !== eg) begin
                $display("FAIL rotate c%0d: got %b expected %b grant %b", i, w_act, model_out(), eg);
                n_err++;
            end
            n_vec++;
        end
        if (dones != 5) begin
            $display("FAIL rotate_done_count: got %0d expected 5", dones); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_priority();
        apply_reset();
        req = 4'b0010; req_len = '0; arb_en = 1'b1; beat_ack = 1'b1;
        tick();
        req = 4'b0011;
        tick();
        tick();
        if (w_act !== model_out() || grant !== 4'b0001 || grant_id !== 2'd0) begin
            $display("FAIL priority_after_m1: got %b expected %b", w_act, model_out()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_timeout();
        int tos = 0, dns = 0, bad = 0;
        apply_reset();
        req = 4'b0100; set_len(2, 5); arb_en = 1'b1; beat_ack = 1'b0;
        for (int i = 1; i <= int'(TO_CYC) + 1; i++) begin
            tick();
            if (timeout) tos++;
            if (done) dns++;
            if (w_act !== model_out()) bad++;
            if (i <= int'(TO_CYC) && grant !== 4'b0100) bad++;
        end
        if (bad != 0 || tos != 1 || dns != 0 || timeout !== 1'b1 || grant !== 4'b0) begin
            $display("FAIL timeout_abort: bad=%0d timeouts=%0d dones=%0d got %b expected %b",
                     bad, tos, dns, w_act, model_out());
            n_err++;
        end
        n_vec++;
        req = 4'b0101;
        tick();
        if (w_act !== model_out() || grant_id !== 2'd0) begin
            $display("FAIL timeout_rotate: got %b expected %b", w_act, model_out()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_ack_at_threshold();
        apply_reset();
        req = 4'b0001; req_len = '0; arb_en = 1'b1; beat_ack = 1'b0;
        for (int i = 1; i <= int'(TO_CYC); i++) tick();
        beat_ack = 1'b1; req = 4'b0;
        tick();
        if (w_act !== model_out() || done !== 1'b1 || timeout !== 1'b0) begin
            $display("FAIL ack_wins_threshold: got %b expected %b", w_act, model_out()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_hold();
        apply_reset();
        req = 4'b0001; set_len(0, 3); arb_en = 1'b1; beat_ack = 1'b1;
        tick(); tick(); tick();
        req = 4'b0000; arb_en = 1'b0; set_len(0, 200);
        for (int i = 4; i <= 9; i++) begin
            tick();
            if (i == 7) req = 4'b1000;
            if (w_act !== model_out() || grant !== ((i == 4) ? 4'b0001 : 4'b0000) ||
                done !== (i == 5)) begin
                $display("FAIL hold_burst c%0d: got %b expected %b", i, w_act, model_out());
                n_err++;
            end
            n_vec++;
        end
        arb_en = 1'b1;
        tick();
        if (w_act !== model_out() || grant !== 4'b1000) begin
            $display("FAIL hold_release_en: got %b expected %b", w_act, model_out()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0001; set_len(0, 3); arb_en = 1'b1; beat_ack = 1'b1;
        tick(); tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        if (grant !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
            $display("FAIL async_reset: got %b expected 0000..0", w_act); n_err++;
        end
        n_vec++;
        @(negedge clk);
        req = 4'b0110; beat_ack = 1'b0; rst = 1'b0;
        tick();
        if (w_act !== model_out() || grant !== 4'b0010) begin
            $display("FAIL reset_then_m1: got %b expected %b", w_act, model_out()); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_max_len();
        int acks = 0, bad = 0;
        bit seen = 0;
        apply_reset();
        req = 4'b0001; set_len(0, 255); arb_en = 1'b1;
        for (int i = 0; i < 1500 && !seen; i++) begin
            beat_ack = ($urandom_range(0, 3) != 0);
            if (busy && beat_ack) acks++;
            tick();
            if (w_act !== model_out()) bad++;
            if (done) seen = 1;
        end
        if (!seen || acks != 256 || bad != 0) begin
            $display("FAIL max_len_burst: done_seen=%0d acks=%0d expected 256 bad=%0d",
                     seen, acks, bad);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            req      = 4'($urandom_range(0, 15));
            arb_en   = ($urandom_range(0, 7) != 0);
            beat_ack = ($urandom_range(0, 9) < 6);
            for (int m = 0; m < 4; m++) set_len(m, int'($urandom_range(0, 6)));
            tick();
            if (w_act !== model_out()) begin
                $display("FAIL random c%0d: got %b expected %b", i, w_act, model_out());
                n_err++;
            end
            n_vec++;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation bound expired at tick %0d", n_tick);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; arb_en = 1'b0; req = 4'b0; req_len = '0; beat_ack = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotate();
        test_priority();
        test_timeout();
        test_ack_at_threshold();
        test_hold();
        test_async_reset();
        test_max_len();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
